// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing a 4:1 mux; registers the selected word
// behind a valid/ready handshake. Optional burst lock under ARB_BURST_LOCK_EN.
module mux_4x1_rr_arbiter #(
    parameter int unsigned DATA_W    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [3:0]        gnt,
    output logic              sel0,
    output logic              sel1,
    output logic [DATA_W-1:0] dout,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;

    logic [1:0]        base;
    logic [1:0]        cand;
    logic [1:0]        pick_idx;
    logic              pick_found;
    logic [DATA_W-1:0] pick_data;

`ifdef ARB_BURST_LOCK_EN
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cur_data;
`endif

    burst_range_a: assert property (@(posedge clk) (MAX_BURST >= 1) && (MAX_BURST <= 15));

    // On a transfer the just-served index becomes the new round-robin origin
    assign base       = (state_q == BUSY) ? sel_q : last_q;
    assign pick_found = |req;

    // First requester in order base+1 .. base+4; lower offsets override later
    always_comb begin
        pick_idx = 2'd0;
        cand     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = base + 2'(k);
            if (req[cand]) begin
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        case (pick_idx)
            2'd0:    pick_data = din0;
            2'd1:    pick_data = din1;
            2'd2:    pick_data = din2;
            default: pick_data = din3;
        endcase
    end

`ifdef ARB_BURST_LOCK_EN
    always_comb begin
        case (sel_q)
            2'd0:    cur_data = din0;
            2'd1:    cur_data = din1;
            2'd2:    cur_data = din2;
            default: cur_data = din3;
        endcase
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
`ifdef ARB_BURST_LOCK_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    sel_d   = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    dout_d  = pick_data;
                    valid_d = 1'b1;
`ifdef ARB_BURST_LOCK_EN
                    cnt_d   = 4'd1;
`endif
                end
            end
            BUSY: begin
                if (out_ready) begin
                    last_d = sel_q;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        gnt_d   = 4'b0001 << pick_idx;
                        dout_d  = pick_data;
`ifdef ARB_BURST_LOCK_EN
                        cnt_d   = 4'd1;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        valid_d = 1'b0;
                    end
`ifdef ARB_BURST_LOCK_EN
                    // Burst lock: same winner keeps the channel, origin not advanced
                    if (req[sel_q] && (cnt_q < 4'(MAX_BURST))) begin
                        state_d = BUSY;
                        last_d  = last_q;
                        sel_d   = sel_q;
                        gnt_d   = gnt_q;
                        dout_d  = cur_data;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + 4'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            dout_q  <= '0;
            valid_q <= 1'b0;
`ifdef ARB_BURST_LOCK_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
`ifdef ARB_BURST_LOCK_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign sel0      = sel_q[0];
    assign sel1      = sel_q[1];
    assign dout      = dout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Self-checking bench for mux_4x1_rr_arbiter (default build): vector table,
// hand-written reset sequences and randomized traffic against a reference model.
module tb_mux_4x1_rr_arbiter;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] din0, din1, din2, din3;
    logic [3:0]    gnt;
    logic          sel0, sel1;
    logic [DW-1:0] dout;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    mux_4x1_rr_arbiter #(.DATA_W(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din0      (din0),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .gnt       (gnt),
        .sel0      (sel0),
        .sel1      (sel1),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    wire [10:0] obs = {gnt, sel1, sel0, dout, out_valid};

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] d0, d1, d2, d3;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [3:0] dout;
        logic       valid;
    } vec_t;

    vec_t tbl [20];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       m_valid;
    logic [1:0] m_idx, m_last;
    logic [3:0] m_dout;

    function automatic vec_t mk(input logic [3:0] r, input logic rdy,
                                input logic [3:0] a, b, c, d,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic [3:0] o, input logic v);
        vec_t t;
        t.req = r; t.rdy = rdy; t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = d;
        t.gnt = g; t.sel = s; t.dout = o; t.valid = v;
        return t;
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {gnt,sel,dout,valid}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic rdy,
                         input logic [3:0] a, b, c, d);
        req = r; out_ready = rdy; din0 = a; din1 = b; din2 = c; din3 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 4'b0; out_ready = 1'b0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0; m_idx = 2'd0; m_last = 2'd3; m_dout = 4'd0;
    endtask

    // Reference: a free or completing channel takes the first requester after
    // the last completed winner; the served index becomes the new origin.
    task automatic model_step(input logic [3:0] r, input logic rdy, input logic [15:0] dv);
        int w;
        if (!m_valid || rdy) begin
            if (m_valid) m_last = m_idx;
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && r[(int'(m_last) + k) % 4]) w = (int'(m_last) + k) % 4;
            end
            if (w >= 0) begin
                m_valid = 1'b1;
                m_idx   = 2'(w);
                m_dout  = dv[w*4 +: 4];
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    function automatic logic [10:0] model_obs();
        logic [3:0] g;
        g = m_valid ? (4'b0001 << m_idx) : 4'b0000;
        return {g, m_idx, m_dout, m_valid};
    endfunction

    initial begin
        logic [3:0]  r;
        logic        rdy;
        logic [15:0] dv;

        tbl[0]  = mk(4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 2'd0, 4'd0, 1'b0);
        tbl[1]  = mk(4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 2'd0, 4'd0, 1'b0);
        tbl[2]  = mk(4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 2'd0, 4'd0, 1'b0);
        tbl[3]  = mk(4'b1111, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 4'b0001, 2'd0, 4'd1, 1'b1);
        tbl[4]  = mk(4'b1111, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 4'b0010, 2'd1, 4'd0, 1'b1);
        tbl[5]  = mk(4'b1111, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 4'b0100, 2'd2, 4'd1, 1'b1);
        tbl[6]  = mk(4'b1111, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 4'b1000, 2'd3, 4'd0, 1'b1);
        tbl[7]  = mk(4'b1111, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 4'b0001, 2'd0, 4'd1, 1'b1);
        tbl[8]  = mk(4'b0000, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0, 4'b0000, 2'd0, 4'd1, 1'b0);
        tbl[9]  = mk(4'b0100, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 4'b0100, 2'd2, 4'd1, 1'b1);
        tbl[10] = mk(4'b0100, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0100, 2'd2, 4'd1, 1'b1);
        tbl[11] = mk(4'b0000, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 4'b0100, 2'd2, 4'd1, 1'b1);
        tbl[12] = mk(4'b0100, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0100, 2'd2, 4'd1, 1'b1);
        tbl[13] = mk(4'b0000, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 2'd2, 4'd1, 1'b0);
        tbl[14] = mk(4'b0101, 1'b0, 4'd3, 4'd4, 4'd5, 4'd6, 4'b0001, 2'd0, 4'd3, 1'b1);
        tbl[15] = mk(4'b0101, 1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 4'b0100, 2'd2, 4'd5, 1'b1);
        tbl[16] = mk(4'b0000, 1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 4'b0000, 2'd2, 4'd5, 1'b0);
        tbl[17] = mk(4'b0010, 1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 4'b0010, 2'd1, 4'd4, 1'b1);
        tbl[18] = mk(4'b0000, 1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 4'b0000, 2'd1, 4'd4, 1'b0);
        tbl[19] = mk(4'b0000, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'b0000, 2'd1, 4'd4, 1'b0);

        do_reset();
        #1;
        check("reset_values", obs, 11'b0);

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].req, tbl[i].rdy, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
            check($sformatf("vec%0d", i), obs,
                  {tbl[i].gnt, tbl[i].sel, tbl[i].dout, tbl[i].valid});
        end

        // Asynchronous reset while a beat is stalled
        apply(4'b0010, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        check("busy_before_reset", obs, {4'b0010, 2'd1, 4'd2, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", obs, 11'b0);
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1000, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        check("post_reset_grant3", obs, {4'b1000, 2'd3, 4'd4, 1'b1});
        apply(4'b0010, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        check("serve1", obs, {4'b0010, 2'd1, 4'd2, 1'b1});
        apply(4'b0000, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        check("serve1_idle", obs, {4'b0000, 2'd1, 4'd2, 1'b0});
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        apply(4'b0110, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        check("reset_restarts_priority", obs, {4'b0010, 2'd1, 4'd2, 1'b1});

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            rdy = ($urandom_range(0, 3) != 0);
            dv  = 16'($urandom);
            model_step(r, rdy, dv);
            apply(r, rdy, dv[3:0], dv[7:4], dv[11:8], dv[15:12]);
            check($sformatf("rand%0d", i), obs, model_obs());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
